audio_frame_decimator: RTL and testbench
========================================

# audio_frame_decimator

Downstream stage of the FIR low-pass filter. Takes the filter's one-cycle `data_ready`/`filtered_audio` pulses and keeps every DECIMATE-th sample. Kept samples are packed into fixed-length frames in a ping-pong pair of buffers. Each completed frame is streamed out over a valid/ready interface with a last marker, for the spectral-analysis stage.

## Interface
- WIDTH, 16: sample width, signed two's complement.
- DECIMATE, 4: keep 1 of every DECIMATE input samples; ≥1.
- FRAME_LEN, 256: kept samples per frame; power of two, ≥2.

Ports:
- clk_in  input  1  single clock; all logic on posedge.
- rst_in  input  1  synchronous, active-high reset.
- sample_in  input  WIDTH  signed sample from FIR `filtered_audio`.
- sample_valid  input  1  one-cycle strobe (FIR `data_ready`).
- m_data  output  WIDTH  frame sample out.
- m_valid  output  1  m_data valid.
- m_last  output  1  high with final (FRAME_LEN-1) sample of frame.
- m_ready  input  1  consumer accepts when m_valid && m_ready.
- overflow  output  1  sticky: a kept sample was dropped; cleared only by reset.

## Operation
- Decimation phase counter 0..DECIMATE-1, advances only on sample_valid, wraps. Sample kept when phase==0 at strobe (first strobe after reset is kept). DECIMATE=1 keeps all.
- Two banks, each FRAME_LEN×WIDTH, states FREE/FILLING/FULL/DRAINING. After reset: bank0 FILLING, bank1 FREE, write index 0.
- Input FSM: FILL, STALL.
  - FILL: each kept sample written at write index, index++. On the FRAME_LEN-th write, bank -> FULL. If the other bank is FREE, or becomes FREE this same cycle, it becomes FILLING, index=0, stay FILL. Otherwise go to STALL.
  - STALL: kept samples discarded, overflow<=1. The first cycle a bank becomes FREE, it becomes FILLING, index=0, -> FILL. Decimation phase keeps counting while in STALL.
- Output FSM: IDLE, STREAM.
  - IDLE: if any bank is FULL, it becomes DRAINING and the FSM enters STREAM. The older frame goes first. Both banks FULL only arises via STALL, and bank order alternates.
  - STREAM: outputs indices 0..FRAME_LEN-1 in order.
  - AXI-style rules: m_data/m_last stable while m_valid && !m_ready; m_valid never drops without a handshake.
  - After the last handshake, the bank becomes FREE and the FSM returns to IDLE.
- Samples are passed through unmodified: no scaling, no sign change. Frames are never torn or interleaved.
- Reset mid-operation: partial and full frames are discarded, and every output returns to its reset value on the next edge.

## Timing
- Reset values: m_data=0, m_valid=0, m_last=0, overflow=0. Bank and FSM states as above, phase=0.
- Buffer read is registered (1-cycle RAM latency). First m_valid rises 2 cycles after the edge on which the bank goes FULL.
- Throughput: with m_ready held high, one sample per cycle. The frame drains in FRAME_LEN cycles after first valid.
- After a handshake, the next m_valid is in the following cycle. Read-ahead prefetch is required, with no bubble.
- After the final handshake, at least 1 idle cycle before the next frame's m_valid.
- Input strobes may arrive every cycle. Write occurs on the strobe's edge and there is no input backpressure.
- Simultaneous: output frees bank X on the same edge input fills bank Y. Y -> FULL and X -> FILLING on that edge; no sample is dropped and overflow stays 0.

## Configuration
- AUDIO_FRAME_DROP_CNT_EN defined: adds output `drop_count` (16 bits, unsigned). It counts kept samples discarded in STALL, saturates at 16'hFFFF, resets to 0, and updates on the same edge as overflow.
- Undefined: port and counter absent; overflow flag behaviour unchanged.

## Test plan
- Decimation: DECIMATE=4, FRAME_LEN=8, inputs 0..31 on consecutive-cycle strobes, m_ready=1 -> one frame 0,4,8,…,28; m_last only with 28; first m_valid 2 cycles after strobe of 28.
- Backpressure: same frame, m_ready toggled 1,0,0,1,… -> m_data/m_last held during stalls, all 8 values delivered in order exactly once.
- Ping-pong: DECIMATE=1, FRAME_LEN=8, 16 back-to-back strobes of -8..7, m_ready=1 -> two frames -8..-1 then 0..7, overflow=0.
- Overflow: m_ready=0, DECIMATE=1, FRAME_LEN=8, 24 strobes of 1..24 -> overflow=1 after strobe 17. Releasing m_ready yields frames 1..8 then 9..16; 17..24 lost. drop_count=8 when AUDIO_FRAME_DROP_CNT_EN is defined.
- Simultaneous free/fill: arrange the last handshake of frame A on the same edge as the 8th write of frame B -> no drop, next frame's write index starts at 0.
- Reset mid-stream: assert rst_in for 1 cycle during drain at index 3 -> next edge m_valid=0, overflow=0. A fresh 8-sample frame after reset is output intact starting from phase 0.

Source files
------------

// File: rtl/audio_frame_decimator.sv
// audio_frame_decimator: keeps every DECIMATE-th FIR output sample and packs the kept
// samples into FRAME_LEN-long frames held in two ping-pong banks. Each full frame is
// streamed out over valid/ready, with m_last marking the final sample of the frame.
// Optional feature macro: AUDIO_FRAME_DROP_CNT_EN adds a saturating 16-bit drop_count
// output that counts kept samples discarded while both banks are occupied.
module audio_frame_decimator #(
  parameter int WIDTH     = 16,
  parameter int DECIMATE  = 4,
  parameter int FRAME_LEN = 256
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic signed [WIDTH-1:0] m_data,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
`ifdef AUDIO_FRAME_DROP_CNT_EN
  output logic [15:0]             drop_count,
`endif
  output logic                    overflow
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int PH_W  = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [PH_W-1:0]  LAST_PH   = PH_W'(DECIMATE - 1);

  typedef enum logic [1:0] {BANK_FREE, BANK_FILLING, BANK_FULL, BANK_DRAINING} bank_t;
  typedef enum logic {IN_FILL, IN_STALL} in_t;
  typedef enum logic {OUT_IDLE, OUT_STREAM} out_t;

  // Both banks live in one array; the top address bit selects the bank.
  logic signed [WIDTH-1:0] mem [2*FRAME_LEN];

  bank_t            bank_state [2];
  in_t              in_state;
  out_t             out_state;
  logic [PH_W-1:0]  phase;
  logic             fill_bank;
  logic             out_bank;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  logic kept;
  logic wr_en;
  logic rd_en;
  logic frame_done;
  logic other_free;

  assign kept       = sample_valid && (phase == '0);
  assign wr_en      = kept && (in_state == IN_FILL);
  // Final handshake of the frame being drained; its bank is released on this edge.
  assign frame_done = (out_state == OUT_STREAM) && m_valid && m_ready && m_last;
  // Fetch the next sample whenever the output register is empty or being consumed,
  // but never past the sample carrying m_last.
  assign rd_en      = (out_state == OUT_STREAM) && !(m_valid && m_last) && (!m_valid || m_ready);
  // The non-filling bank is free now, or is released by the output side this edge.
  assign other_free = (bank_state[~fill_bank] == BANK_FREE) ||
                      (frame_done && (out_bank == ~fill_bank));

  // Sample write port of the buffer RAM.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[{fill_bank, wr_idx}] <= sample_in;
    end
  end

  // Registered read port of the buffer RAM, which doubles as the output data register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      m_data <= '0;
    end else if (rd_en) begin
      m_data <= mem[{out_bank, rd_idx}];
    end
  end

  // Decimation phase, bank ownership, input FILL/STALL and output IDLE/STREAM control.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      phase         <= '0;
      in_state      <= IN_FILL;
      out_state     <= OUT_IDLE;
      bank_state[0] <= BANK_FILLING;
      bank_state[1] <= BANK_FREE;
      fill_bank     <= 1'b0;
      out_bank      <= 1'b0;
      wr_idx        <= '0;
      rd_idx        <= '0;
      m_valid       <= 1'b0;
      m_last        <= 1'b0;
      overflow      <= 1'b0;
`ifdef AUDIO_FRAME_DROP_CNT_EN
      drop_count    <= '0;
`endif
    end else begin
      if (sample_valid) begin
        phase <= (phase == LAST_PH) ? '0 : phase + 1'b1;
      end

      // Output side. Frames complete in alternating bank order, so out_bank simply
      // toggles after each drained frame and always names the older full frame.
      case (out_state)
        OUT_IDLE: begin
          if (bank_state[out_bank] == BANK_FULL) begin
            bank_state[out_bank] <= BANK_DRAINING;
            rd_idx               <= '0;
            out_state            <= OUT_STREAM;
          end
        end
        OUT_STREAM: begin
          if (frame_done) begin
            m_valid              <= 1'b0;
            m_last               <= 1'b0;
            bank_state[out_bank] <= BANK_FREE;
            out_bank             <= ~out_bank;
            out_state            <= OUT_IDLE;
          end else if (rd_en) begin
            m_valid <= 1'b1;
            m_last  <= (rd_idx == LAST_IDX);
            rd_idx  <= rd_idx + 1'b1;
          end
        end
        default: out_state <= OUT_IDLE;
      endcase

      // Input side comes second so a bank released and refilled on the same edge
      // ends up FILLING rather than FREE.
      case (in_state)
        IN_FILL: begin
          if (kept) begin
            wr_idx <= wr_idx + 1'b1;
            if (wr_idx == LAST_IDX) begin
              bank_state[fill_bank] <= BANK_FULL;
              if (other_free) begin
                bank_state[~fill_bank] <= BANK_FILLING;
                fill_bank              <= ~fill_bank;
                wr_idx                 <= '0;
              end else begin
                in_state <= IN_STALL;
              end
            end
          end
        end
        IN_STALL: begin
`ifdef AUDIO_FRAME_DROP_CNT_EN
          if (kept) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) begin
              drop_count <= drop_count + 16'd1;
            end
          end
`else
          if (kept) begin
            overflow <= 1'b1;
          end
`endif
          if (other_free) begin
            bank_state[~fill_bank] <= BANK_FILLING;
            fill_bank              <= ~fill_bank;
            wr_idx                 <= '0;
            in_state               <= IN_FILL;
          end
        end
        default: in_state <= IN_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_frame_decimator.sv
// Testbench for audio_frame_decimator: two instances (DECIMATE=4 and DECIMATE=1,
// FRAME_LEN=8) share stimulus; a queue-based frame model scores every output cycle.
// Honours AUDIO_FRAME_DROP_CNT_EN when defined.
module tb_audio_frame_decimator;
  localparam int W  = 16;
  localparam int FL = 8;
  localparam int DEC_M [2] = '{4, 1};

  logic                clk    = 1'b0;
  logic                rst_in = 1'b1;
  logic signed [W-1:0] sample = '0;
  logic                sval   = 1'b0;
  logic                rdy    = 1'b0;

  logic signed [W-1:0] d4, d1;
  logic                v4, v1, l4, l1, o4, o1;
`ifdef AUDIO_FRAME_DROP_CNT_EN
  logic [15:0]         dc4, dc1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance: index 0 is the DECIMATE=4 instance, 1 the DECIMATE=1 one.
  typedef struct {
    int d;
    bit last;
  } exp_t;
  exp_t exp_q  [2][$];   // samples of completed frames not yet handed over
  exp_t part_q [2][$];   // frame currently being collected
  int   log_q  [2][$];   // every value the DUT handed over
  int   phase_m   [2] = '{0, 0};
  int   held_m    [2] = '{0, 0};
  bit   stalled_m [2] = '{0, 0};
  bit   ovf_m     [2] = '{0, 0};
  bit   hold_prev [2] = '{0, 0};

  typedef struct {
    logic                sv;
    logic signed [W-1:0] s;
    logic                r;
    logic                ev;
    logic signed [W-1:0] ed;
    logic                el;
  } vec_t;

  audio_frame_decimator #(.WIDTH(W), .DECIMATE(4), .FRAME_LEN(FL)) u4 (
    .clk_in(clk), .rst_in(rst_in), .sample_in(sample), .sample_valid(sval),
    .m_data(d4), .m_valid(v4), .m_last(l4), .m_ready(rdy),
`ifdef AUDIO_FRAME_DROP_CNT_EN
    .drop_count(dc4),
`endif
    .overflow(o4)
  );

  audio_frame_decimator #(.WIDTH(W), .DECIMATE(1), .FRAME_LEN(FL)) u1 (
    .clk_in(clk), .rst_in(rst_in), .sample_in(sample), .sample_valid(sval),
    .m_data(d1), .m_valid(v1), .m_last(l1), .m_ready(rdy),
`ifdef AUDIO_FRAME_DROP_CNT_EN
    .drop_count(dc1),
`endif
    .overflow(o1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int log_at(input int i, input int k);
    if (k < log_q[i].size()) return log_q[i][k];
    return -99999;
  endfunction

  // Frame-level model: kept samples collect into frames; a completed frame waits for
  // output; with two frames waiting there is no space, so kept samples are dropped
  // until a frame has been fully handed over.
  task automatic sb_step();
    int    dq [2];
    bit    vq [2], lq [2], oq [2];
    bit    kept, freed, was_stalled;
    exp_t  e;
    string tag;
    dq[0] = int'(d4); dq[1] = int'(d1);
    vq[0] = v4;       vq[1] = v1;
    lq[0] = l4;       lq[1] = l1;
    oq[0] = o4;       oq[1] = o1;
    for (int i = 0; i < 2; i++) begin
      tag = (i == 0) ? "u4" : "u1";
      if (rst_in) begin
        exp_q[i].delete();
        part_q[i].delete();
        log_q[i].delete();
        phase_m[i] = 0; held_m[i] = 0; stalled_m[i] = 0; ovf_m[i] = 0; hold_prev[i] = 0;
      end else begin
        freed       = 0;
        was_stalled = stalled_m[i];
        chk(oq[i] == ovf_m[i], {tag, ".overflow"}, oq[i], ovf_m[i]);
        if (hold_prev[i]) chk(vq[i], {tag, ".valid_dropped_without_handshake"}, vq[i], 1);
        if (vq[i]) begin
          if (exp_q[i].size() == 0) begin
            chk(0, {tag, ".unexpected_valid"}, dq[i], 0);
          end else begin
            chk(dq[i] == exp_q[i][0].d, {tag, ".data"}, dq[i], exp_q[i][0].d);
            chk(lq[i] == exp_q[i][0].last, {tag, ".last"}, lq[i], exp_q[i][0].last);
          end
          if (rdy) begin
            log_q[i].push_back(dq[i]);
            if (exp_q[i].size() > 0) begin
              e = exp_q[i].pop_front();
              if (e.last) begin
                held_m[i]--;
                freed = 1;
              end
            end
          end
        end
        hold_prev[i] = vq[i] && !rdy;
        if (sval) begin
          kept = (phase_m[i] == 0);
          phase_m[i] = (phase_m[i] + 1) % DEC_M[i];
          if (kept) begin
            if (stalled_m[i]) begin
              ovf_m[i] = 1;
            end else begin
              e.d    = int'(sample);
              e.last = (part_q[i].size() == FL - 1);
              part_q[i].push_back(e);
              if (part_q[i].size() == FL) begin
                while (part_q[i].size() > 0) exp_q[i].push_back(part_q[i].pop_front());
                held_m[i]++;
                if (held_m[i] == 2) stalled_m[i] = 1;
              end
            end
          end
        end
        if (was_stalled && freed) stalled_m[i] = 0;
      end
    end
  endtask

  // One clock: score at the falling edge, then return just after the rising edge.
  task automatic step();
    @(negedge clk);
    sb_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1; sval = 1'b0; rdy = 1'b0; sample = '0;
    step();
    step();
    rst_in = 1'b0;
  endtask

  initial begin
    vec_t vecs [40];
    int   c;
    for (int i = 0; i < 40; i++) begin
      vecs[i].sv = (i < 32);
      vecs[i].s  = W'(i);
      vecs[i].r  = 1'b1;
      vecs[i].ev = (i >= 30) && (i <= 37);
      vecs[i].ed = vecs[i].ev ? W'(4 * (i - 30)) : '0;
      vecs[i].el = (i == 37);
    end

    // Reset values
    do_reset();
    chk(v4 == 0, "reset.m_valid", v4, 0);
    chk(d4 == 0, "reset.m_data", d4, 0);
    chk(l4 == 0, "reset.m_last", l4, 0);
    chk(o4 == 0, "reset.overflow", o4, 0);
    chk(v1 == 0, "reset.u1.m_valid", v1, 0);
    chk(o1 == 0, "reset.u1.overflow", o1, 0);

    // Decimation by 4: table of per-cycle inputs and expected u4 outputs
    for (int i = 0; i < 40; i++) begin
      sval = vecs[i].sv; sample = vecs[i].s; rdy = vecs[i].r;
      step();
      chk(v4 == vecs[i].ev, $sformatf("decim.valid[%0d]", i), v4, vecs[i].ev);
      if (vecs[i].ev) begin
        chk(d4 == vecs[i].ed, $sformatf("decim.data[%0d]", i), d4, vecs[i].ed);
        chk(l4 == vecs[i].el, $sformatf("decim.last[%0d]", i), l4, vecs[i].el);
      end
    end

    // Backpressure: m_ready pattern 1,0,0,1,0,0,...
    do_reset();
    c = 0;
    while (log_q[0].size() < FL && c < 300) begin
      sval = (c < 32); sample = W'(c); rdy = (c % 3 == 0);
      step();
      c++;
    end
    sval = 1'b0; rdy = 1'b1;
    repeat (5) step();
    chk(log_q[0].size() == FL, "bp.count", log_q[0].size(), FL);
    for (int k = 0; k < FL; k++) chk(log_at(0, k) == 4 * k, $sformatf("bp.value[%0d]", k), log_at(0, k), 4 * k);

    // Ping-pong: 16 back-to-back strobes -8..7 into the DECIMATE=1 instance
    do_reset();
    c = 0;
    while (log_q[1].size() < 16 && c < 200) begin
      sval = (c < 16); sample = W'(c - 8); rdy = 1'b1;
      step();
      c++;
    end
    sval = 1'b0;
    repeat (5) step();
    chk(log_q[1].size() == 16, "pingpong.count", log_q[1].size(), 16);
    for (int k = 0; k < 16; k++) chk(log_at(1, k) == k - 8, $sformatf("pingpong.value[%0d]", k), log_at(1, k), k - 8);
    chk(o1 == 0, "pingpong.overflow", o1, 0);

    // Overflow: consumer stalled, 24 strobes 1..24
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      sval = 1'b1; sample = W'(k);
      step();
      if (k == 16) chk(o1 == 0, "ovf.after_strobe16", o1, 0);
      if (k == 17) chk(o1 == 1, "ovf.after_strobe17", o1, 1);
    end
    sval = 1'b0; rdy = 1'b1; c = 0;
    while (log_q[1].size() < 16 && c < 200) begin
      step();
      c++;
    end
    repeat (10) step();
    chk(log_q[1].size() == 16, "ovf.count", log_q[1].size(), 16);
    for (int k = 0; k < 16; k++) chk(log_at(1, k) == k + 1, $sformatf("ovf.value[%0d]", k), log_at(1, k), k + 1);
`ifdef AUDIO_FRAME_DROP_CNT_EN
    chk(dc1 == 16'd8, "ovf.drop_count", dc1, 8);
    chk(dc4 == 16'd0, "ovf.u4.drop_count", dc4, 0);
`else
    chk(o4 == 0, "ovf.u4.overflow", o4, 0);
`endif

    // Simultaneous free/fill: last handshake of frame A on the 8th write of frame B
    do_reset();
    rdy = 1'b1;
    for (int cc = 0; cc < 26; cc++) begin
      sval   = (cc < 8) || (cc >= 10);
      sample = (cc < 8) ? W'(100 + cc) : (cc < 18) ? W'(200 + cc - 10) : W'(300 + cc - 18);
      step();
      if (cc == 16) begin
        chk(v1 == 1, "simul.last_valid", v1, 1);
        chk(l1 == 1, "simul.last_flag", l1, 1);
      end
    end
    sval = 1'b0; c = 0;
    while (log_q[1].size() < 24 && c < 200) begin
      step();
      c++;
    end
    chk(o1 == 0, "simul.overflow", o1, 0);
    chk(log_q[1].size() == 24, "simul.count", log_q[1].size(), 24);
    for (int k = 0; k < 24; k++) begin
      int exp_v;
      exp_v = (k < 8) ? 100 + k : (k < 16) ? 200 + k - 8 : 300 + k - 16;
      chk(log_at(1, k) == exp_v, $sformatf("simul.value[%0d]", k), log_at(1, k), exp_v);
    end

    // Reset mid-stream at drain index 3, then a fresh frame
    do_reset();
    rdy = 1'b1;
    for (int cc = 0; cc < 32; cc++) begin
      sval = 1'b1; sample = W'(cc);
      step();
    end
    sval = 1'b0; c = 0;
    while (!(v4 && d4 == 12) && c < 40) begin
      step();
      c++;
    end
    chk(v4 == 1 && d4 == 12, "rst.reached_index3", d4, 12);
    chk(o1 == 1, "rst.u1_overflow_before", o1, 1);
    rst_in = 1'b1;
    step();
    chk(v4 == 0, "rst.m_valid", v4, 0);
    chk(d4 == 0, "rst.m_data", d4, 0);
    chk(l4 == 0, "rst.m_last", l4, 0);
    chk(o4 == 0, "rst.overflow", o4, 0);
    chk(v1 == 0, "rst.u1.m_valid", v1, 0);
    chk(o1 == 0, "rst.u1.overflow", o1, 0);
    rst_in = 1'b0;
    for (int cc = 0; cc < 32; cc++) begin
      sval = 1'b1; sample = W'(500 + cc);
      step();
    end
    sval = 1'b0; c = 0;
    while (log_q[0].size() < FL && c < 60) begin
      step();
      c++;
    end
    chk(log_q[0].size() == FL, "rst.fresh_count", log_q[0].size(), FL);
    for (int k = 0; k < FL; k++) chk(log_at(0, k) == 500 + 4 * k, $sformatf("rst.fresh_value[%0d]", k), log_at(0, k), 500 + 4 * k);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
